// File: rtl/lap_stopwatch.sv
// Two-digit seconds stopwatch with lap ring buffer, lap recall and hold-to-clear, scanning a two-digit 7-segment display.
// Latency: button press acts 3 cycles after the raw edge, hold actions HOLD_SEC*CLK_FREQ+2 cycles after it; AN lags value/CA by 1 cycle.
// Backpressure: none; free-running, button events act on the cycle they occur and are never queued.
module lap_stopwatch #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int MAX_SEC   = 60,
    parameter int LAP_DEPTH = 5,
    parameter int HOLD_SEC  = 3,
    parameter int SCAN_DIV  = 125_000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             BTN0,
    input  logic                             BTN1,
    output logic [6:0]                       AN,
    output logic                             CA,
    output logic [1:0]                       STATE,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   LAP_CNT
);
    localparam int HOLD_CYC = HOLD_SEC * CLK_FREQ;
    localparam int HW  = $clog2(HOLD_CYC + 1);
    localparam int PSW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int SW  = $clog2(MAX_SEC);
    localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STOP  = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    logic [1:0]     sync_a, sync_b, sync_c;
    logic [1:0]     press, hold_evt;
    logic [HW-1:0]  hold_cnt [2];
    logic [1:0]     state;
    logic [PSW-1:0] pcnt;
    logic [SW-1:0]  sec;
    logic [PW-1:0]  wp, rp, oldest, newest, wp_inc, rp_inc;
    logic [CW-1:0]  lap_cnt;
    logic [6:0]     lap_mem [LAP_DEPTH];
    logic [6:0]     disp_val;
    logic [3:0]     tens, ones;
    logic [DW-1:0]  scan_cnt;
    logic           tick, push, go_clear, go_load;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Two-flop synchronisers plus a third stage used for rise detection.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_a <= '0;
            sync_b <= '0;
            sync_c <= '0;
        end else begin
            sync_a <= {BTN1, BTN0};
            sync_b <= sync_a;
            sync_c <= sync_b;
        end
    end

    // Hold counters run while the button is high and park one past the fire point, so the hold event is a single pulse.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST || !sync_b[i])
                hold_cnt[i] <= '0;
            else if (hold_cnt[i] != HW'(HOLD_CYC))
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
    end

    // Button events and the derived per-cycle actions.
    always_comb begin
        press    = sync_b & ~sync_c;
        hold_evt = '0;
        for (int i = 0; i < 2; i++)
            hold_evt[i] = sync_b[i] && (hold_cnt[i] == HW'(HOLD_CYC - 1));
        tick     = (state == S_RUN) && (pcnt == PSW'(CLK_FREQ - 1));
        push     = (state == S_RUN) && press[1];
        go_clear = ((state == S_STOP) || (state == S_LOAD)) && hold_evt[1];
        go_load  = (state == S_STOP) && hold_evt[0] && !hold_evt[1];
    end

    // Ring pointer arithmetic: oldest/newest valid entries and modulo increments.
    always_comb begin
        oldest = PW'((int'(wp) + LAP_DEPTH - int'(lap_cnt)) % LAP_DEPTH);
        newest = PW'((int'(wp) + LAP_DEPTH - 1) % LAP_DEPTH);
        wp_inc = (int'(wp) == LAP_DEPTH - 1) ? '0 : wp + 1'b1;
        rp_inc = (int'(rp) == LAP_DEPTH - 1) ? '0 : rp + 1'b1;
    end

    // Mode FSM; a BTN1 hold beats a BTN0 hold, and a BTN0 press in STOP resumes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_CLEAR;
        end else begin
            case (state)
                S_CLEAR: if (press[0]) state <= S_RUN;
                S_RUN:   if (press[0]) state <= S_STOP;
                S_STOP: begin
                    if (hold_evt[1])      state <= S_CLEAR;
                    else if (hold_evt[0]) state <= S_LOAD;
                    else if (press[0])    state <= S_RUN;
                end
                S_LOAD: begin
                    if (hold_evt[1])      state <= S_CLEAR;
                    else if (press[0])    state <= S_STOP;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Prescaler and seconds: advance only in RUN, phase is kept across STOP/LOAD, zeroed on entry to CLEAR.
    always_ff @(posedge CLK) begin
        if (!RST || go_clear) begin
            pcnt <= '0;
            sec  <= '0;
        end else if (state == S_RUN) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick)
                sec <= (sec == SW'(MAX_SEC - 1)) ? '0 : sec + 1'b1;
        end
    end

    // Lap write side: store the pre-tick seconds, overwrite the oldest entry when full.
    always_ff @(posedge CLK) begin
        if (!RST || go_clear) begin
            wp      <= '0;
            lap_cnt <= '0;
        end else if (push) begin
            wp      <= wp_inc;
            lap_cnt <= (int'(lap_cnt) == LAP_DEPTH) ? lap_cnt : lap_cnt + 1'b1;
        end
    end

    // Lap storage has no reset; LAP_CNT alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (push)
            lap_mem[wp] <= 7'(sec);
    end

    // Recall pointer: starts at the oldest lap on LOAD entry, BTN1 walks newer and wraps back to oldest.
    always_ff @(posedge CLK) begin
        if (!RST || go_clear)
            rp <= '0;
        else if (go_load)
            rp <= oldest;
        else if ((state == S_LOAD) && press[1] && (lap_cnt != '0))
            rp <= (rp == newest) ? oldest : rp_inc;
    end

    // Displayed value split into BCD digits.
    always_comb begin
        disp_val = 7'(sec);
        if (state == S_LOAD)
            disp_val = (lap_cnt == '0) ? 7'd0 : lap_mem[rp];
        tens = 4'(disp_val / 7'd10);
        ones = 4'(disp_val % 7'd10);
    end

    // Digit scan: CA flips every SCAN_DIV cycles, AN registers the digit CA currently selects.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            scan_cnt <= '0;
            CA       <= 1'b0;
            AN       <= 7'h3F;
        end else begin
            if (scan_cnt == DW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                CA       <= ~CA;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            AN <= seg7(CA ? tens : ones);
        end
    end

    assign STATE   = state;
    assign LAP_CNT = lap_cnt;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch at CLK_FREQ=100, HOLD_SEC=3, LAP_DEPTH=5, MAX_SEC=60, SCAN_DIV=10.
// Step table drives buttons at scheduled cycles; check steps queue expectations and compare when reached.
// Hand sequences cover exact hold timing, mid-run reset and digit-scan timing.
module tb_lap_stopwatch;
    localparam int CLK_FREQ  = 100;
    localparam int MAX_SEC   = 60;
    localparam int LAP_DEPTH = 5;
    localparam int HOLD_SEC  = 3;
    localparam int SCAN_DIV  = 10;

    localparam int OP_CHK = 0, OP_RST = 1, OP_LVL = 2, OP_PULSE = 3, OP_END = 4;

    typedef struct packed {
        int at; int op; int arg; int st; int lap; int val;
    } step_t;

    typedef struct packed {
        int idx; int st; int lap; int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn0 = 1'b0;
    logic       btn1 = 1'b0;
    logic [6:0] an;
    logic       ca;
    logic [1:0] state;
    logic [2:0] lap_cnt;

    int    cyc_cnt = 0;
    int    base = 0;
    int    total = 0;
    int    bad = 0;
    int    sp = 0;
    step_t steps[$];
    exp_t  sb_q[$];
    logic [6:0] seg_tab [10];

    lap_stopwatch #(
        .CLK_FREQ(CLK_FREQ), .MAX_SEC(MAX_SEC), .LAP_DEPTH(LAP_DEPTH),
        .HOLD_SEC(HOLD_SEC), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .CLK(clk), .RST(rst), .BTN0(btn0), .BTN1(btn1),
        .AN(an), .CA(ca), .STATE(state), .LAP_CNT(lap_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: cycle=%0d limit=60000", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string what, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s [%0d]: got 0x%0h want 0x%0h", what, idx, act, exp);
        end
    endtask

    task automatic add(input int at, input int op, input int arg, input int st, input int lap, input int val);
        step_t s;
        s.at = at; s.op = op; s.arg = arg; s.st = st; s.lap = lap; s.val = val;
        steps.push_back(s);
    endtask

    task automatic add_chk(input int at, input int st, input int lap, input int val);
        add(at, OP_CHK, 0, st, lap, val);
    endtask

    task automatic wait_until(input int t);
        while (cyc_cnt - base < t) @(negedge clk);
    endtask

    // Both digits are compared once CA has been steady for a cycle (AN has caught up).
    task automatic disp_chk(input int idx, input int val);
        logic p;
        bit   got_o, got_t;
        p = ca; got_o = 0; got_t = 0;
        for (int k = 0; k < 40 && !(got_o && got_t); k++) begin
            @(negedge clk);
            if (ca == p) begin
                if (!ca && !got_o) begin
                    cmp("an_ones", idx, int'(an), int'(seg_tab[val % 10]));
                    got_o = 1;
                end else if (ca && !got_t) begin
                    cmp("an_tens", idx, int'(an), int'(seg_tab[val / 10]));
                    got_t = 1;
                end
            end
            p = ca;
        end
        if (!(got_o && got_t)) begin
            total++; bad++;
            $display("FAIL disp_timeout [%0d]: got no steady CA phase want both phases", idx);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        cmp("state", e.idx, int'(state), e.st);
        cmp("lap_cnt", e.idx, int'(lap_cnt), e.lap);
        disp_chk(e.idx, e.val);
    endtask

    task automatic expect_now(input int idx, input int st, input int lap, input int val);
        exp_t e;
        e.idx = idx; e.st = st; e.lap = lap; e.val = val;
        sb_q.push_back(e);
        check_front();
    endtask

    task automatic run_seg();
        step_t s;
        while (sp < steps.size() && steps[sp].op != OP_END) begin
            s = steps[sp];
            if (s.op != OP_RST) wait_until(s.at);
            case (s.op)
                OP_RST: begin
                    btn0 = 0; btn1 = 0; rst = 0;
                    repeat (2) @(negedge clk);
                    rst = 1;
                    base = cyc_cnt;
                end
                OP_LVL: begin
                    btn0 = s.arg[0]; btn1 = s.arg[1];
                end
                OP_PULSE: begin
                    btn0 = s.arg[0]; btn1 = s.arg[1];
                    repeat (2) @(negedge clk);
                    btn0 = 0; btn1 = 0;
                end
                default: expect_now(sp, s.st, s.lap, s.val);
            endcase
            sp++;
        end
        sp++;
    endtask

    // CA period and the one-cycle AN lag after each CA flip.
    task automatic ca_check(input int val);
        logic p;
        int   t1;
        bit   ok;
        for (int ph = 0; ph < 2; ph++) begin
            p = ca; ok = 0;
            for (int k = 0; k < 25 && !ok; k++) begin
                @(negedge clk);
                if (ca != p) ok = 1;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL ca_toggle [%0d]: got no toggle want toggle within 25", ph);
                return;
            end
            t1 = cyc_cnt;
            cmp("an_lag", ph, int'(an), int'(ca ? seg_tab[val % 10] : seg_tab[val / 10]));
            @(negedge clk);
            cmp("an_new", ph, int'(an), int'(ca ? seg_tab[val / 10] : seg_tab[val % 10]));
            p = ca; ok = 0;
            for (int k = 0; k < 25 && !ok; k++) begin
                @(negedge clk);
                if (ca != p) ok = 1;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL ca_toggle2 [%0d]: got no toggle want toggle within 25", ph);
                return;
            end
            cmp("ca_period", ph, cyc_cnt - t1, SCAN_DIV);
        end
    endtask

    // STOP + BTN1 held: CLEAR lands exactly HOLD_SEC*CLK_FREQ+2 cycles after the raw rise.
    task automatic exact_clear();
        int c;
        wait_until(850);
        btn1 = 1;
        c = cyc_cnt;
        while (cyc_cnt < c + HOLD_SEC * CLK_FREQ + 1) @(negedge clk);
        cmp("clr_before", 0, int'(state), 2);
        @(negedge clk);
        cmp("clr_state", 0, int'(state), 0);
        cmp("clr_lap", 0, int'(lap_cnt), 0);
        btn1 = 0;
        expect_now(900, 0, 0, 0);
    endtask

    // Reset while running with laps, taken while the tens digit (non-3F) is on AN.
    task automatic reset_mid();
        logic p;
        bit   found;
        wait_until(1450);
        p = ca; found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (ca && p) found = 1;
            else p = ca;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL rst_window: got no tens phase want tens phase within 40");
            return;
        end
        cmp("pre_rst_an", 0, int'(an), int'(seg_tab[1]));
        rst = 0;
        @(negedge clk);
        cmp("rst_state", 0, int'(state), 0);
        cmp("rst_lap", 0, int'(lap_cnt), 0);
        cmp("rst_ca", 0, int'(ca), 0);
        cmp("rst_an", 0, int'(an), 'h3F);
        rst = 1;
    endtask

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

        // A: run 20 s, stop with a simultaneous lap, stays frozen 5 s.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add_chk(100, 1, 0, 0); add(2090, OP_PULSE, 3, 0, 0, 0);
        add_chk(2110, 2, 1, 20); add_chk(2610, 2, 1, 20); add(0, OP_END, 0, 0, 0, 0);
        // B: 65 s wrap with laps at 20 and 35, recall both and wrap, back to STOP.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(2090, OP_PULSE, 2, 0, 0, 0); add(3590, OP_PULSE, 2, 0, 0, 0);
        add_chk(6593, 1, 2, 5); add(6620, OP_LVL, 1, 0, 0, 0); add(6930, OP_LVL, 0, 0, 0, 0);
        add_chk(6940, 3, 2, 20); add(6970, OP_PULSE, 2, 0, 0, 0); add_chk(6980, 3, 2, 35);
        add(7010, OP_PULSE, 2, 0, 0, 0); add_chk(7020, 3, 2, 20);
        add(7050, OP_PULSE, 1, 0, 0, 0); add_chk(7060, 2, 2, 5); add(0, OP_END, 0, 0, 0, 0);
        // C: six laps overflow depth 5, recall order, LOAD hold advances then clears, restart.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(590, OP_PULSE, 2, 0, 0, 0); add(2090, OP_PULSE, 2, 0, 0, 0); add(2590, OP_PULSE, 2, 0, 0, 0);
        add(3090, OP_PULSE, 2, 0, 0, 0); add(3590, OP_PULSE, 2, 0, 0, 0); add(4090, OP_PULSE, 2, 0, 0, 0);
        add_chk(4110, 1, 5, 40); add(4200, OP_LVL, 1, 0, 0, 0); add(4510, OP_LVL, 0, 0, 0, 0);
        add_chk(4520, 3, 5, 20);
        add(4560, OP_PULSE, 2, 0, 0, 0); add_chk(4570, 3, 5, 25);
        add(4600, OP_PULSE, 2, 0, 0, 0); add_chk(4610, 3, 5, 30);
        add(4640, OP_PULSE, 2, 0, 0, 0); add_chk(4650, 3, 5, 35);
        add(4680, OP_PULSE, 2, 0, 0, 0); add_chk(4690, 3, 5, 40);
        add(4720, OP_PULSE, 2, 0, 0, 0); add_chk(4730, 3, 5, 20);
        add(4760, OP_LVL, 2, 0, 0, 0); add_chk(4780, 3, 5, 25); add(5100, OP_LVL, 0, 0, 0, 0);
        add_chk(5110, 0, 0, 0); add(5150, OP_PULSE, 1, 0, 0, 0);
        add_chk(5200, 1, 0, 0); add_chk(5300, 1, 0, 1); add(0, OP_END, 0, 0, 0, 0);
        // D: short BTN1 hold in STOP changes nothing (exact clear follows by hand).
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(290, OP_PULSE, 2, 0, 0, 0); add(390, OP_PULSE, 1, 0, 0, 0);
        add(420, OP_LVL, 2, 0, 0, 0); add(670, OP_LVL, 0, 0, 0, 0);
        add_chk(700, 2, 1, 3); add_chk(800, 2, 1, 3); add(0, OP_END, 0, 0, 0, 0);
        // E: three laps while running (mid-run reset follows by hand).
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(190, OP_PULSE, 2, 0, 0, 0); add(290, OP_PULSE, 2, 0, 0, 0); add(390, OP_PULSE, 2, 0, 0, 0);
        add_chk(450, 1, 3, 4); add(0, OP_END, 0, 0, 0, 0);
        // F: both buttons together: lap + STOP, then both holds together: CLEAR wins.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(250, OP_LVL, 3, 0, 0, 0); add_chk(270, 2, 1, 2); add(600, OP_LVL, 0, 0, 0, 0);
        add_chk(610, 0, 0, 0); add(0, OP_END, 0, 0, 0, 0);
        // G: lap coincident with tick stores the pre-increment value.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(340, OP_PULSE, 2, 0, 0, 0); add_chk(360, 1, 1, 3); add(400, OP_LVL, 1, 0, 0, 0);
        add(710, OP_LVL, 0, 0, 0, 0); add_chk(720, 3, 1, 2); add(0, OP_END, 0, 0, 0, 0);
        // H: LOAD with no laps shows 00, BTN0 returns to the frozen count.
        add(0, OP_RST, 0, 0, 0, 0); add_chk(0, 0, 0, 0); add(40, OP_PULSE, 1, 0, 0, 0);
        add(250, OP_LVL, 1, 0, 0, 0); add(560, OP_LVL, 0, 0, 0, 0); add_chk(570, 3, 0, 0);
        add(600, OP_PULSE, 1, 0, 0, 0); add_chk(610, 2, 0, 2); add(0, OP_END, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        run_seg(); ca_check(20);
        run_seg();
        run_seg();
        run_seg(); exact_clear();
        run_seg(); reset_mid();
        run_seg();
        run_seg();
        run_seg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised two-digit seconds stopwatch with start/stop, lap capture into a ring buffer of configurable depth, lap recall (LOAD) mode and hold-to-clear. It drives the two-digit Pmod seven-segment display directly (segment bus plus digit select). It extends the single-depth stopwatch with configurable clock rate, wrap modulus, lap depth, hold time and display scan rate.

## Interface
- CLK_FREQ, 125_000_000: CLK cycles per second.
- MAX_SEC, 60: seconds wrap modulus, 2..100; count runs 0..MAX_SEC-1.
- LAP_DEPTH, 5: lap ring-buffer entries, 1..16.
- HOLD_SEC, 3: button hold time in seconds for hold actions.
- SCAN_DIV, 125_000: CLK cycles per digit-select toggle.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- BTN0  in  1  start/stop; hold for LOAD. Raw, asynchronous.
- BTN1  in  1  lap / next lap; hold for CLEAR. Raw, asynchronous.
- AN  out  7  segments {g,f,e,d,c,b,a}, active-high.
- CA  out  1  digit select: 0 = ones digit, 1 = tens digit.
- STATE  out  2  0 CLEAR, 1 RUN, 2 STOP, 3 LOAD.
- LAP_CNT  out  $clog2(LAP_DEPTH+1)  number of valid stored laps.

## Operation
- Each button passes through a 2-flop synchroniser, then:
  - a rise detector, giving a 1-cycle press event;
  - a hold counter that clears while the synchronised level is low, and increments while it is high.
  - The hold counter fires a single 1-cycle hold event when it reaches HOLD_SEC*CLK_FREQ-1. It saturates until release.
- Prescaler counts 0..CLK_FREQ-1 only in RUN.
  - It holds its value in STOP and LOAD; it is zero in CLEAR.
  - It emits a tick at terminal count.
  - On tick, seconds increments and wraps from MAX_SEC-1 to 0.
- Ring buffer:
  - Write pointer wp and read pointer rp.
  - A push writes the current seconds at wp and advances wp modulo LAP_DEPTH.
  - LAP_CNT increments and saturates at LAP_DEPTH. When full, a push overwrites the oldest entry.
- States:
  - CLEAR: seconds=0, prescaler=0, LAP_CNT=0, wp=0. BTN0 press -> RUN.
  - RUN: counting. BTN1 press -> push lap. BTN0 press -> STOP. Hold events are ignored.
  - STOP: count frozen. BTN0 press -> RUN (resume, prescaler phase preserved). BTN1 hold -> CLEAR. BTN0 hold -> LOAD.
    - The hold event may originate from the same press that caused RUN->STOP.
  - LOAD:
    - On entry, rp = oldest valid entry: (wp-LAP_CNT) mod LAP_DEPTH.
    - BTN1 press advances rp to the next newer entry; it wraps from newest to oldest.
    - BTN1 hold -> CLEAR. BTN0 press -> STOP, showing the frozen count.
    - The BTN1 press that starts a clearing hold also advances rp first.
- Display value: lap entry at rp in LOAD (00 if LAP_CNT=0); seconds otherwise.
  - Value splits into tens/ones BCD, using digit codes 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - CA toggles every SCAN_DIV cycles in all states.
  - AN is registered and shows the digit selected by the current CA.

## Timing
- Reset (RST low at a rising edge) results:
  - STATE=0, seconds=0, prescaler=0, LAP_CNT=0, wp=rp=0;
  - CA=0, AN=7'h3F;
  - synchronisers, hold counters and scan counter cleared.
- Reset mid-operation discards all laps.
- Button press to state/push effect: 3 cycles (2 sync + 1 registered action).
- A hold action occurs HOLD_SEC*CLK_FREQ+2 cycles after the raw rise, give or take one cycle.
- Seconds changes on the cycle after prescaler terminal count. AN reflects a new value 1 cycle after the value or CA changes.
- Simultaneous events:
  - Lap push coincident with tick stores the pre-increment value.
  - BTN0 and BTN1 press in the same RUN cycle: the lap is pushed AND the state goes to STOP.
  - BTN0 and BTN1 hold events in the same STOP cycle: CLEAR wins.
  - Press while the button is already high: no event.

## Test plan
Bench parameters: CLK_FREQ=100, HOLD_SEC=3, LAP_DEPTH=5, MAX_SEC=60, SCAN_DIV=10.
- Reset, BTN0 pulse, run 20 s, BTN0 pulse -> STATE=2, seconds stays 20 for 5 s; CA toggles every 10 cycles; AN alternates 3F / 5B.
- Run continuously 65 s from CLEAR -> seconds wraps 59->0 and reads 5. A BTN1 pulse at 20 s and at 35 s gives LAP_CNT=2, entries 20, 35.
- Six laps at 5,20,25,30,35,40 s, then STOP, BTN0 held 3 s -> LOAD. Display shows 20. Five BTN1 pulses show 25,30,35,40,20. LAP_CNT=5.
- In STOP, BTN1 held 3 s -> CLEAR exactly HOLD_SEC*CLK_FREQ+2 cycles after the raw rise. Seconds=0, LAP_CNT=0, AN=3F. A BTN1 held under 3 s causes no change.
- In LOAD, BTN1 held 3 s -> rp advances once, then CLEAR. A later BTN0 pulse starts from 0.
- Reset asserted mid-RUN with 3 laps -> all outputs equal reset values on the next cycle. Lap-at-tick pushes the pre-increment value.
